// File: rtl/nunchuck_ctrl_if.sv
// Command/done bus between the nunchuck sequencer (master side) and the
// I2C byte engine (slave side). Byte 0 of each data bus is the first on the wire.
interface nunchuck_ctrl_if #(
    parameter int unsigned MAX_BYTES = 6
);
    localparam int unsigned NBW = $clog2(MAX_BYTES + 2);

    logic                      i2c_start;
    logic                      i2c_disable;
    logic                      i2c_write;
    logic [6:0]                i2c_devAddr;
    logic [7:0]                i2c_regAddr;
    logic [NBW-1:0]            i2c_numBytes;
    logic [MAX_BYTES-1:0][7:0] i2c_dataIn;
    logic                      i2c_done;
    logic [MAX_BYTES-1:0][7:0] i2c_dataOut;

    modport master (
        output i2c_start, i2c_disable, i2c_write, i2c_devAddr,
               i2c_regAddr, i2c_numBytes, i2c_dataIn,
        input  i2c_done, i2c_dataOut
    );

    modport slave (
        input  i2c_start, i2c_disable, i2c_write, i2c_devAddr,
               i2c_regAddr, i2c_numBytes, i2c_dataIn,
        output i2c_done, i2c_dataOut
    );
endinterface

// File: rtl/nunchuck_ctrl.sv
// Wii Nunchuck sequencer: unencrypted init, then a pointer-write / wait / 6-byte
// read poll loop, decoding each read into joystick, accelerometer and buttons.
module nunchuck_ctrl #(
    parameter logic [6:0]  DEV_ADDR       = 7'h52,
    parameter int unsigned MAX_BYTES      = 6,
    parameter int unsigned CONV_CYCLES    = 600,
    parameter int unsigned POLL_CYCLES    = 30000,
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    nunchuck_ctrl_if.master       i2c,
    output logic [7:0]            joy_x,
    output logic [7:0]            joy_y,
    output logic [9:0]            accel_x,
    output logic [9:0]            accel_y,
    output logic [9:0]            accel_z,
    output logic                  btn_c,
    output logic                  btn_z,
    output logic                  sample_valid,
    output logic                  init_done,
    output logic [7:0]            err_cnt
);
    localparam int unsigned NBW      = $clog2(MAX_BYTES + 2);
    localparam int unsigned WAIT_MAX = (CONV_CYCLES > POLL_CYCLES) ? CONV_CYCLES : POLL_CYCLES;
    localparam int unsigned WW       = $clog2(WAIT_MAX + 1);
    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, INIT1, INIT2, PTR, CONV_WAIT, READ, DECODE, POLL_WAIT
    } state_e;

    typedef enum logic [1:0] {
        T_ISSUE, T_BUSY, T_WAIT, T_ABORT
    } txn_e;

    state_e         state_q, state_d;
    txn_e           txn_q, txn_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           abort_q, abort_d;
    logic           start_q, start_d;
    logic           dis_q, dis_d;
    logic           sv_q, sv_d;
    logic           init_done_q, init_done_d;
    logic [7:0]     err_q, err_d;
    logic [7:0]     joy_x_q, joy_x_d, joy_y_q, joy_y_d;
    logic [9:0]     acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
    logic           btn_c_q, btn_c_d, btn_z_q, btn_z_d;

    logic           in_txn;
    logic           txn_ok;

    assign in_txn = state_q inside {INIT1, INIT2, PTR, READ};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            txn_q       <= T_ISSUE;
            wait_q      <= '0;
            tmo_q       <= '0;
            abort_q     <= 1'b0;
            start_q     <= 1'b0;
            dis_q       <= 1'b0;
            sv_q        <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= '0;
            joy_x_q     <= '0;
            joy_y_q     <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            acc_z_q     <= '0;
            btn_c_q     <= 1'b0;
            btn_z_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            wait_q      <= wait_d;
            tmo_q       <= tmo_d;
            abort_q     <= abort_d;
            start_q     <= start_d;
            dis_q       <= dis_d;
            sv_q        <= sv_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            joy_x_q     <= joy_x_d;
            joy_y_q     <= joy_y_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            acc_z_q     <= acc_z_d;
            btn_c_q     <= btn_c_d;
            btn_z_q     <= btn_z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        abort_d = abort_q;
        txn_ok  = 1'b0;

        if (in_txn) begin
            case (txn_q)
                T_ISSUE: begin
                    if (i2c.i2c_done) begin
                        txn_d = T_BUSY;
                        tmo_d = '0;
                    end
                end
                T_BUSY: begin
                    tmo_d = tmo_q + TW'(1);
                    if (!i2c.i2c_done) txn_d = T_WAIT;
                end
                T_WAIT: begin
                    tmo_d = tmo_q + TW'(1);
                    if (i2c.i2c_done) txn_ok = 1'b1;
                end
                default: begin
                    if (!abort_q) begin
                        abort_d = 1'b1;
                    end else begin
                        abort_d = 1'b0;
                        txn_d   = T_ISSUE;
                        if (!enable)
                            state_d = IDLE;
                        else if (state_q == INIT1 || state_q == INIT2)
                            state_d = INIT1;
                        else
                            state_d = PTR;
                    end
                end
            endcase

            // A transaction that has not finished by the deadline is aborted
            if ((txn_q == T_BUSY || txn_q == T_WAIT) && !txn_ok &&
                tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                txn_d   = T_ABORT;
                abort_d = 1'b0;
            end

            if (txn_ok) begin
                txn_d  = T_ISSUE;
                wait_d = '0;
                case (state_q)
                    INIT1:   state_d = enable ? INIT2 : IDLE;
                    INIT2:   state_d = enable ? PTR : IDLE;
                    PTR:     state_d = enable ? CONV_WAIT : IDLE;
                    default: state_d = DECODE;
                endcase
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = init_done_q ? PTR : INIT1;
                        txn_d   = T_ISSUE;
                    end
                end
                CONV_WAIT: begin
                    if (wait_q == WW'(CONV_CYCLES - 1)) begin
                        state_d = READ;
                        txn_d   = T_ISSUE;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                // The DECODE cycle is the first cycle of the poll interval
                DECODE: begin
                    wait_d  = wait_q + WW'(1);
                    state_d = POLL_WAIT;
                end
                default: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (wait_q == WW'(POLL_CYCLES - 1)) begin
                        state_d = PTR;
                        txn_d   = T_ISSUE;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        start_d     = in_txn && txn_q == T_ISSUE && i2c.i2c_done;
        dis_d       = (txn_d == T_ABORT);
        sv_d        = 1'b0;
        init_done_d = init_done_q;
        err_d       = err_q;
        joy_x_d     = joy_x_q;
        joy_y_d     = joy_y_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        acc_z_d     = acc_z_q;
        btn_c_d     = btn_c_q;
        btn_z_d     = btn_z_q;

        if (txn_q != T_ABORT && txn_d == T_ABORT && err_q != 8'hFF)
            err_d = err_q + 8'd1;

        if (txn_ok && state_q == INIT2)
            init_done_d = 1'b1;

        if (txn_ok && state_q == READ) begin
            sv_d    = 1'b1;
            joy_x_d = i2c.i2c_dataOut[0];
            joy_y_d = i2c.i2c_dataOut[1];
            acc_x_d = {i2c.i2c_dataOut[2], i2c.i2c_dataOut[5][3:2]};
            acc_y_d = {i2c.i2c_dataOut[3], i2c.i2c_dataOut[5][5:4]};
            acc_z_d = {i2c.i2c_dataOut[4], i2c.i2c_dataOut[5][7:6]};
            btn_c_d = ~i2c.i2c_dataOut[5][1];
            btn_z_d = ~i2c.i2c_dataOut[5][0];
        end
    end

    // Command fields follow the main state, so they hold for the whole transaction
    always_comb begin
        i2c.i2c_write    = 1'b0;
        i2c.i2c_regAddr  = '0;
        i2c.i2c_numBytes = '0;
        i2c.i2c_dataIn   = '0;
        case (state_q)
            INIT1: begin
                i2c.i2c_write     = 1'b1;
                i2c.i2c_regAddr   = 8'hF0;
                i2c.i2c_numBytes  = NBW'(1);
                i2c.i2c_dataIn[0] = 8'h55;
            end
            INIT2: begin
                i2c.i2c_write    = 1'b1;
                i2c.i2c_regAddr  = 8'hFB;
                i2c.i2c_numBytes = NBW'(1);
            end
            PTR: begin
                i2c.i2c_write = 1'b1;
            end
            READ: begin
                i2c.i2c_numBytes = NBW'(6);
            end
            default: ;
        endcase
    end

    assign i2c.i2c_start   = start_q;
    assign i2c.i2c_disable = dis_q;
    assign i2c.i2c_devAddr = DEV_ADDR;
    assign joy_x           = joy_x_q;
    assign joy_y           = joy_y_q;
    assign accel_x         = acc_x_q;
    assign accel_y         = acc_y_q;
    assign accel_z         = acc_z_q;
    assign btn_c           = btn_c_q;
    assign btn_z           = btn_z_q;
    assign sample_valid    = sv_q;
    assign init_done       = init_done_q;
    assign err_cnt         = err_q;
endmodule

// File: tb/tb_nunchuck_ctrl.sv
// Scoreboard bench for nunchuck_ctrl: a behavioural I2C master answers commands,
// expected commands/samples are queued by the stimulus and checked by a monitor.
module tb_nunchuck_ctrl;
    localparam int unsigned CONV = 20;
    localparam int unsigned POLL = 40;
    localparam int unsigned TMO  = 200;
    localparam int unsigned LAT  = 50;

    typedef struct packed {
        logic       wr;
        logic [7:0] ra;
        logic [2:0] nb;
        logic [7:0] d0;
    } cmd_t;

    typedef struct packed {
        logic [7:0] jx;
        logic [7:0] jy;
        logic [9:0] ax;
        logic [9:0] ay;
        logic [9:0] az;
        logic       bc;
        logic       bz;
    } smp_t;

    localparam cmd_t INIT1_C = '{1'b1, 8'hF0, 3'd1, 8'h55};
    localparam cmd_t INIT2_C = '{1'b1, 8'hFB, 3'd1, 8'h00};
    localparam cmd_t PTR_C   = '{1'b1, 8'h00, 3'd0, 8'h00};
    localparam cmd_t READ_C  = '{1'b0, 8'h00, 3'd6, 8'h00};

    // Hand-decoded samples for the three read vectors below
    localparam smp_t S1 = '{8'h80, 8'h7F, 10'h297, 10'h169, 10'h3FE, 1'b0, 1'b1};
    localparam smp_t S2 = '{8'h10, 8'h20, 10'h0C0, 10'h100, 10'h140, 1'b0, 1'b0};
    localparam smp_t S3 = '{8'h01, 8'hFE, 10'h001, 10'h3FD, 10'h0F1, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] joy_x, joy_y, err_cnt;
    logic [9:0] accel_x, accel_y, accel_z;
    logic       btn_c, btn_z, sample_valid, init_done;

    always #5 clk = ~clk;

    nunchuck_ctrl_if #(.MAX_BYTES(6)) bus ();

    nunchuck_ctrl #(
        .DEV_ADDR(7'h52),
        .MAX_BYTES(6),
        .CONV_CYCLES(CONV),
        .POLL_CYCLES(POLL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .i2c(bus),
        .joy_x(joy_x),
        .joy_y(joy_y),
        .accel_x(accel_x),
        .accel_y(accel_y),
        .accel_z(accel_z),
        .btn_c(btn_c),
        .btn_z(btn_z),
        .sample_valid(sample_valid),
        .init_done(init_done),
        .err_cnt(err_cnt)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    cmd_t exp_cmd[$];
    smp_t exp_smp[$];

    // master model state
    logic [5:0][7:0] rdata;
    bit   hang_read = 0;
    bit   m_busy = 0, m_hang = 0, m_write = 0, m_ptr = 0;
    int   m_lat = 0;
    int   completions = 0;
    int   ptr_done_cyc = -1;

    // monitor state
    int   n_starts = 0, n_samples = 0, dis_run = 0, sv_cyc = 0;
    bit   prev_start = 0, prev_sv = 0, poll_armed = 0;
    cmd_t ec;
    smp_t es;
    int   s0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic set_rdata(input logic [7:0] b0, b1, b2, b3, b4, b5);
        rdata[0] = b0; rdata[1] = b1; rdata[2] = b2;
        rdata[3] = b3; rdata[4] = b4; rdata[5] = b5;
    endtask

    // Behavioural I2C master: done drops after start, returns after LAT cycles
    initial begin : master_model
        bus.i2c_done    = 1'b1;
        bus.i2c_dataOut = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || bus.i2c_disable) begin
                m_busy       = 0;
                bus.i2c_done = 1'b1;
            end else if (m_busy) begin
                if (!m_hang) begin
                    m_lat++;
                    if (m_lat >= LAT) begin
                        m_busy       = 0;
                        bus.i2c_done = 1'b1;
                        if (!m_write) bus.i2c_dataOut = rdata;
                        if (m_ptr) ptr_done_cyc = cyc + 1;
                        completions++;
                    end
                end
            end else if (bus.i2c_start) begin
                m_busy       = 1;
                m_lat        = 0;
                m_write      = bus.i2c_write;
                m_ptr        = bus.i2c_write && bus.i2c_numBytes == 3'd0;
                m_hang       = !bus.i2c_write && hang_read;
                bus.i2c_done = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 0; prev_sv = 0; dis_run = 0; poll_armed = 0;
            end else begin
                if (bus.i2c_start) begin
                    check("start_one_cycle", {31'b0, prev_start}, 0);
                    n_starts++;
                    if (exp_cmd.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_start: got write=%0d reg=0x%0h, expected no command",
                                 bus.i2c_write, bus.i2c_regAddr);
                    end else begin
                        ec = exp_cmd.pop_front();
                        check("cmd_write", {31'b0, bus.i2c_write}, {31'b0, ec.wr});
                        check("cmd_regAddr", {24'b0, bus.i2c_regAddr}, {24'b0, ec.ra});
                        check("cmd_numBytes", {29'b0, bus.i2c_numBytes}, {29'b0, ec.nb});
                        check("cmd_data0", {24'b0, bus.i2c_dataIn[0]}, {24'b0, ec.d0});
                        check("cmd_data_rest_zero", {31'b0, bus.i2c_dataIn[5:1] == '0}, 1);
                        check("cmd_devAddr", {25'b0, bus.i2c_devAddr}, 32'h52);
                    end
                    if (!bus.i2c_write && ptr_done_cyc >= 0)
                        check("conv_gap", cyc - ptr_done_cyc, CONV + 1);
                    if (bus.i2c_write && bus.i2c_numBytes == 3'd0 && poll_armed)
                        check("poll_gap", cyc - sv_cyc, POLL + 1);
                    poll_armed = 0;
                end
                if (sample_valid) begin
                    check("sample_valid_one_cycle", {31'b0, prev_sv}, 0);
                    n_samples++;
                    sv_cyc     = cyc;
                    poll_armed = enable;
                    if (exp_smp.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_sample: got joy_x=0x%0h, expected no sample", joy_x);
                    end else begin
                        es = exp_smp.pop_front();
                        check("joy_x", {24'b0, joy_x}, {24'b0, es.jx});
                        check("joy_y", {24'b0, joy_y}, {24'b0, es.jy});
                        check("accel_x", {22'b0, accel_x}, {22'b0, es.ax});
                        check("accel_y", {22'b0, accel_y}, {22'b0, es.ay});
                        check("accel_z", {22'b0, accel_z}, {22'b0, es.az});
                        check("btn_c", {31'b0, btn_c}, {31'b0, es.bc});
                        check("btn_z", {31'b0, btn_z}, {31'b0, es.bz});
                    end
                end
                if (bus.i2c_disable) begin
                    dis_run++;
                end else if (dis_run != 0) begin
                    check("disable_width", dis_run, 2);
                    dis_run = 0;
                end
                prev_start = bus.i2c_start;
                prev_sv    = sample_valid;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, {31'b0, bus.i2c_start}, 0);
        check({tag, "_disable"}, {31'b0, bus.i2c_disable}, 0);
        check({tag, "_write"}, {31'b0, bus.i2c_write}, 0);
        check({tag, "_devAddr"}, {25'b0, bus.i2c_devAddr}, 32'h52);
        check({tag, "_regAddr"}, {24'b0, bus.i2c_regAddr}, 0);
        check({tag, "_numBytes"}, {29'b0, bus.i2c_numBytes}, 0);
        check({tag, "_dataIn"}, {31'b0, bus.i2c_dataIn == '0}, 1);
        check({tag, "_joy"}, {16'b0, joy_x, joy_y}, 0);
        check({tag, "_accel"}, {2'b0, accel_x, accel_y, accel_z}, 0);
        check({tag, "_btns"}, {30'b0, btn_c, btn_z}, 0);
        check({tag, "_sample_valid"}, {31'b0, sample_valid}, 0);
        check({tag, "_init_done"}, {31'b0, init_done}, 0);
        check({tag, "_err_cnt"}, {24'b0, err_cnt}, 0);
    endtask

    initial begin : stimulus
        set_rdata(8'h80, 8'h7F, 8'hA5, 8'h5A, 8'hFF, 8'b10_01_11_10);
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        exp_cmd.push_back(INIT1_C);
        exp_cmd.push_back(INIT2_C);
        exp_cmd.push_back(PTR_C);
        exp_cmd.push_back(READ_C);
        exp_smp.push_back(S1);
        rst    = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < 1000 && !init_done; i++) @(negedge clk);
        check("init_done_rise", {31'b0, init_done}, 1);
        check("init_done_after_init2_start", n_starts, 2);
        check("init_done_after_two_writes", completions, 2);

        for (int i = 0; i < 1000 && n_samples < 1; i++) @(negedge clk);
        check("sample1_seen", n_samples, 1);

        // next read hangs: expect a 2-cycle abort, err_cnt=1 and a retry from PTR
        hang_read = 1;
        exp_cmd.push_back(PTR_C);
        exp_cmd.push_back(READ_C);
        for (int i = 0; i < 2000 && !bus.i2c_disable; i++) @(negedge clk);
        check("timeout_disable_seen", {31'b0, bus.i2c_disable}, 1);
        hang_read = 0;
        set_rdata(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h03);
        exp_cmd.push_back(PTR_C);
        exp_cmd.push_back(READ_C);
        exp_smp.push_back(S2);
        repeat (3) @(negedge clk);
        check("err_cnt_after_timeout", {24'b0, err_cnt}, 1);
        check("held_joy", {16'b0, joy_x, joy_y}, {16'b0, 8'h80, 8'h7F});
        check("held_accel", {2'b0, accel_x, accel_y, accel_z}, {2'b0, 10'h297, 10'h169, 10'h3FE});
        check("held_btns", {30'b0, btn_c, btn_z}, 32'b01);
        check("no_sample_on_timeout", n_samples, 1);

        for (int i = 0; i < 1000 && n_samples < 2; i++) @(negedge clk);
        check("sample2_seen", n_samples, 2);

        // drop enable in CONV_WAIT: the read still completes, then idle
        set_rdata(8'h01, 8'hFE, 8'h00, 8'hFF, 8'h3C, 8'h55);
        exp_cmd.push_back(PTR_C);
        exp_cmd.push_back(READ_C);
        exp_smp.push_back(S3);
        s0 = completions;
        for (int i = 0; i < 1000 && completions < s0 + 1; i++) @(negedge clk);
        check("ptr_completed", completions, s0 + 1);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 1000 && n_samples < 3; i++) @(negedge clk);
        check("sample3_seen", n_samples, 3);
        s0 = n_starts;
        repeat (POLL + 30) @(negedge clk);
        check("idle_no_start", n_starts, s0);
        check("init_done_kept", {31'b0, init_done}, 1);
        exp_cmd.push_back(PTR_C);
        exp_cmd.push_back(READ_C);
        enable = 1'b1;
        for (int i = 0; i < 100 && n_starts < s0 + 1; i++) @(negedge clk);
        check("resume_ptr_issued", n_starts, s0 + 1);

        // async reset in the middle of the read, between clock edges
        for (int i = 0; i < 300 && n_starts < s0 + 2; i++) @(negedge clk);
        check("read_issued", n_starts, s0 + 2);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        check("queues_drained", exp_cmd.size() + exp_smp.size(), 0);

        exp_cmd.push_back(INIT1_C);
        exp_cmd.push_back(INIT2_C);
        repeat (2) @(negedge clk);
        s0  = n_starts;
        rst = 1'b0;
        for (int i = 0; i < 500 && n_starts < s0 + 2; i++) @(negedge clk);
        check("reinit_two_writes", n_starts, s0 + 2);
        enable = 1'b0;
        for (int i = 0; i < 200 && !init_done; i++) @(negedge clk);
        check("reinit_done", {31'b0, init_done}, 1);
        repeat (10) @(negedge clk);
        check("final_queues_drained", exp_cmd.size() + exp_smp.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
